// File: rtl/key_expansion_ctrl.sv
// AES-128 key schedule sequencer: loads a cipher key and emits round keys 0..10, one per clock.
// Optional round-key store with registered read port is enabled by defining KEY_EXPANSION_STORE_EN.
module key_expansion_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int RK_W       = 128
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            start,
    input  logic [RK_W-1:0] key_in,
    output logic [31:0]     sub_word_out,
    input  logic [31:0]     sub_word_in,
    output logic [RK_W-1:0] round_key,
    output logic [3:0]      round_num,
    output logic            key_valid,
    output logic            busy,
    output logic            done
`ifdef KEY_EXPANSION_STORE_EN
    ,
    input  logic [3:0]      rd_addr,
    output logic [RK_W-1:0] rd_key,
    output logic            store_full
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [3:0] PRE_LAST   = 4'(NUM_ROUNDS - 1);

    // GF(2^8) multiply-by-two used to advance the round constant
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] shifted;
        shifted = {b[6:0], 1'b0};
        return b[7] ? (shifted ^ 8'h1b) : shifted;
    endfunction

    state_t          state_r, state_nx_s;
    logic [RK_W-1:0] round_key_r, round_key_nx_s;
    logic [3:0]      round_num_r, round_num_nx_s;
    logic            key_valid_r, key_valid_nx_s;
    logic            busy_r, busy_nx_s;
    logic            done_r, done_nx_s;
    logic [7:0]      rcon_r, rcon_nx_s;

    logic [31:0]     temp_s, n0_s, n1_s, n2_s, n3_s;
    logic [RK_W-1:0] expanded_s;

    assign sub_word_out = {round_key_r[23:0], round_key_r[31:24]};
    assign round_key    = round_key_r;
    assign round_num    = round_num_r;
    assign key_valid    = key_valid_r;
    assign busy         = busy_r;
    assign done         = done_r;

    // Next round key from the current one; sub_word_in is SubWord(RotWord(w3)) returned this cycle
    always_comb begin
        temp_s     = sub_word_in ^ {rcon_r, 24'h000000};
        n0_s       = round_key_r[127:96] ^ temp_s;
        n1_s       = round_key_r[95:64]  ^ n0_s;
        n2_s       = round_key_r[63:32]  ^ n1_s;
        n3_s       = round_key_r[31:0]   ^ n2_s;
        expanded_s = {n0_s, n1_s, n2_s, n3_s};
    end

    // FSM next-state and registered-output next values
    always_comb begin
        state_nx_s     = state_r;
        round_key_nx_s = round_key_r;
        round_num_nx_s = round_num_r;
        key_valid_nx_s = 1'b0;
        busy_nx_s      = busy_r;
        done_nx_s      = 1'b0;
        rcon_nx_s      = rcon_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s     = ST_EXPAND;
                    round_key_nx_s = key_in;
                    round_num_nx_s = 4'd0;
                    key_valid_nx_s = 1'b1;
                    busy_nx_s      = 1'b1;
                    rcon_nx_s      = 8'h01;
                end else begin
                    busy_nx_s      = 1'b0;
                end
            end
            ST_EXPAND: begin
                // start is ignored throughout EXPAND, including the cycle round 10 is shown
                if (round_num_r == LAST_ROUND) begin
                    state_nx_s     = ST_IDLE;
                    busy_nx_s      = 1'b0;
                end else begin
                    round_key_nx_s = expanded_s;
                    round_num_nx_s = round_num_r + 4'd1;
                    key_valid_nx_s = 1'b1;
                    busy_nx_s      = 1'b1;
                    rcon_nx_s      = xtime(rcon_r);
                    if (round_num_r == PRE_LAST) begin
                        done_nx_s  = 1'b1;
                    end else begin
                        done_nx_s  = 1'b0;
                    end
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= ST_IDLE;
            round_key_r <= {RK_W{1'b0}};
            round_num_r <= 4'd0;
            key_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rcon_r      <= 8'h01;
        end else begin
            state_r     <= state_nx_s;
            round_key_r <= round_key_nx_s;
            round_num_r <= round_num_nx_s;
            key_valid_r <= key_valid_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
            rcon_r      <= rcon_nx_s;
        end
    end

`ifdef KEY_EXPANSION_STORE_EN
    logic [RK_W-1:0] store_mem_r [0:NUM_ROUNDS];
    logic [RK_W-1:0] rd_key_r, rd_key_nx_s;
    logic            store_full_r, store_full_nx_s;
    logic            start_accept_s;

    assign start_accept_s = (state_r == ST_IDLE) && start;
    assign rd_key         = rd_key_r;
    assign store_full     = store_full_r;

    // Read mux (out-of-range addresses read as zero) and full-flag next value
    always_comb begin
        rd_key_nx_s     = {RK_W{1'b0}};
        store_full_nx_s = store_full_r;
        if (rd_addr <= LAST_ROUND) begin
            rd_key_nx_s = store_mem_r[rd_addr];
        end else begin
            rd_key_nx_s = {RK_W{1'b0}};
        end
        if (start_accept_s) begin
            store_full_nx_s = 1'b0;
        end else if (done_nx_s) begin
            store_full_nx_s = 1'b1;
        end else begin
            store_full_nx_s = store_full_r;
        end
    end

    // Key store writes, registered read port and full flag
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                store_mem_r[i] <= {RK_W{1'b0}};
            end
            rd_key_r     <= {RK_W{1'b0}};
            store_full_r <= 1'b0;
        end else begin
            if (key_valid_r) begin
                store_mem_r[round_num_r] <= round_key_r;
            end
            rd_key_r     <= rd_key_nx_s;
            store_full_r <= store_full_nx_s;
        end
    end
`endif

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Randomized self-checking bench for key_expansion_ctrl with a word-level AES key-schedule model
// and an arithmetic S-box feeding sub_word_in.
module tb_key_expansion_ctrl;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [127:0] key_in;
    logic [31:0]  sub_word_out;
    logic [31:0]  sub_word_in;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         key_valid;
    logic         busy;
    logic         done;
`ifdef KEY_EXPANSION_STORE_EN
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;
    logic         store_full;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expansion_ctrl dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .key_in       (key_in),
        .sub_word_out (sub_word_out),
        .sub_word_in  (sub_word_in),
        .round_key    (round_key),
        .round_num    (round_num),
        .key_valid    (key_valid),
        .busy         (busy),
        .done         (done)
`ifdef KEY_EXPANSION_STORE_EN
        ,
        .rd_addr      (rd_addr),
        .rd_key       (rd_key),
        .store_full   (store_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    function automatic logic [7:0] sbox_fn(input logic [7:0] a);
        logic [7:0] inv, s;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    assign sub_word_in = {sbox_fn(sub_word_out[31:24]), sbox_fn(sub_word_out[23:16]),
                          sbox_fn(sub_word_out[15:8]),  sbox_fn(sub_word_out[7:0])};

    logic [7:0] sbox_t [0:255];
    initial for (int i = 0; i < 256; i++) sbox_t[i] = sbox_fn(8'(i));

    // Round r of the AES-128 schedule from the FIPS-197 word recurrence
    function automatic logic [127:0] rk_of(input logic [127:0] k, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: pos_m is the round shown this cycle (-1 when idle); hold_m is the round still held on the outputs
    int           pos_m;
    int           hold_m;
    logic [127:0] key_m;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pos_m  <= -1;
            hold_m <= -1;
            key_m  <= 128'd0;
        end else if (pos_m == -1) begin
            if (start) begin
                pos_m  <= 0;
                hold_m <= 0;
                key_m  <= key_in;
            end
        end else if (pos_m == 10) begin
            pos_m <= -1;
        end else begin
            pos_m  <= pos_m + 1;
            hold_m <= pos_m + 1;
        end
    end

    function automatic logic [127:0] exp_key();
        return (hold_m < 0) ? 128'd0 : rk_of(key_m, hold_m);
    endfunction

    always @(negedge clk) begin
        chk("key_valid", 128'(key_valid), 128'(pos_m >= 0));
        chk("busy", 128'(busy), 128'(pos_m >= 0));
        chk("done", 128'(done), 128'(pos_m == 10));
        chk("round_num", 128'(round_num), (hold_m < 0) ? 128'd0 : 128'(hold_m));
        chk("round_key", round_key, exp_key());
        chk("sub_word_out", 128'(sub_word_out), 128'({exp_key()[23:0], exp_key()[31:24]}));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        chk("idle_wait", 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        int kv_cnt, dn_cnt;
        logic [127:0] k;
        n_rst = 1'b1; start = 1'b0; key_in = 128'd0;
`ifdef KEY_EXPANSION_STORE_EN
        rd_addr = 4'd0;
`endif
        #2 n_rst = 1'b0;
        step(); step();
        chk("rst_round_key", round_key, 128'd0);
        chk("rst_round_num", 128'(round_num), 128'd0);
        chk("rst_key_valid", 128'(key_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        n_rst = 1'b1;
        step();

        // FIPS-197 key
        key_in = FIPS_KEY; start = 1'b1; step(); start = 1'b0;
        chk("fips_r0", round_key, FIPS_KEY);
        step();
        chk("fips_r1", round_key, FIPS_R1);
        repeat (9) step();
        chk("fips_r10", round_key, FIPS_R10);
        chk("fips_r10_done", 128'(done), 128'd1);
        chk("fips_r10_num", 128'(round_num), 128'd10);
        step();
        chk("fips_idle_valid", 128'(key_valid), 128'd0);
        chk("fips_idle_hold", round_key, FIPS_R10);
`ifdef KEY_EXPANSION_STORE_EN
        rd_addr = 4'd1; step();
        chk("store_rd1", rd_key, FIPS_R1);
        rd_addr = 4'd12; step();
        chk("store_rd12", rd_key, 128'd0);
        rd_addr = 4'd10; step();
        chk("store_rd10", rd_key, FIPS_R10);
        chk("store_full_set", 128'(store_full), 128'd1);
`endif

        // All-zero key
        key_in = 128'd0; start = 1'b1; step(); start = 1'b0;
        chk("zero_swo_r0", 128'(sub_word_out), 128'd0);
`ifdef KEY_EXPANSION_STORE_EN
        chk("store_full_clr", 128'(store_full), 128'd0);
`endif
        step();
        chk("zero_r1", round_key, ZERO_R1);
        repeat (9) step();
        chk("zero_r10", round_key, ZERO_R10);
        step();

        // start re-pulsed at rounds 3 and 7 with a different key
        key_in = rand128(); start = 1'b1; step(); start = 1'b0;
        kv_cnt = 0; dn_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            kv_cnt += int'(key_valid);
            dn_cnt += int'(done);
            start  = (c == 3 || c == 7);
            if (start) key_in = rand128();
            step();
        end
        start = 1'b0;
        chk("repulse_valid_cnt", 128'(kv_cnt), 128'd11);
        chk("repulse_done_cnt", 128'(dn_cnt), 128'd1);
        wait_idle();

        // Reset at round 5, then a fresh FIPS run with rcon restarting at 01
        key_in = rand128(); start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        chk("abort_at_r5", 128'(round_num), 128'd5);
        n_rst = 1'b0; #1;
        chk("abort_valid", 128'(key_valid), 128'd0);
        chk("abort_key", round_key, 128'd0);
        chk("abort_num", 128'(round_num), 128'd0);
        step(); step();
        n_rst = 1'b1; step();
        key_in = FIPS_KEY; start = 1'b1; step(); start = 1'b0;
        chk("after_abort_r0", round_key, FIPS_KEY);
        step();
        chk("after_abort_r1", round_key, FIPS_R1);
        wait_idle();
        step();

        // start held high: one IDLE cycle between runs
        k = rand128(); key_in = k; start = 1'b1;
        step();
        chk("b2b_r0", round_key, k);
        repeat (10) step();
        chk("b2b_done", 128'(done), 128'd1);
        step();
        chk("b2b_gap_valid", 128'(key_valid), 128'd0);
        chk("b2b_gap_busy", 128'(busy), 128'd0);
        step();
        chk("b2b_restart_valid", 128'(key_valid), 128'd1);
        chk("b2b_restart_num", 128'(round_num), 128'd0);
        start = 1'b0;
        wait_idle();

        // Randomized runs with stray start pulses and occasional resets
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) step();
            key_in = rand128(); start = 1'b1; step(); start = 1'b0;
            for (int c = 0; c < 12; c++) begin
                if (it % 8 == 5 && c == 4) begin
                    n_rst = 1'b0; step(); n_rst = 1'b1;
                end
                start  = ($urandom_range(0, 3) == 0);
                key_in = rand128();
                step();
            end
            start = 1'b0;
            wait_idle();
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
